// File: rtl/sender_pkg.sv
// Shared constants and helpers for the sender datapath (queue and sender FSM).
package sender_pkg;

    localparam int unsigned SENDER_MAX_BITS = 128;
    localparam int unsigned DROP_CNT_W      = 16;

    // Width of a bit-count field able to hold 0..max_bits inclusive.
    function automatic int unsigned sender_len_w(input int unsigned max_bits);
        return $clog2(max_bits + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 enable,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 grant_valid
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW:0]   idx;

    // Cyclic search starting at rr_ptr; pointer moves past the winner only on a grant.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_PORTS)) begin
                idx = idx - (PW+1)'(NUM_PORTS);
            end
            if (enable && !grant_valid && req[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                grant_valid        = 1'b1;
                rr_ptr_d           = (idx == (PW+1)'(NUM_PORTS - 1)) ? '0 : idx[PW-1:0] + PW'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/sender_queue.sv
// Multi-producer variable-length message queue with a registered head for the serial sender.
module sender_queue
    import sender_pkg::*;
#(
    parameter  int unsigned DEPTH     = 178,
    parameter  int unsigned MAX_BITS  = SENDER_MAX_BITS,
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned LEN_W     = sender_len_w(MAX_BITS),
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    input  logic [NUM_PORTS*MAX_BITS-1:0] in_data,
    input  logic [NUM_PORTS*LEN_W-1:0]    in_bits,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_BITS-1:0]           out_data,
    output logic [LEN_W-1:0]              out_bits,
    output logic [CNT_W-1:0]              count,
    output logic                          full,
    output logic [DROP_CNT_W-1:0]         drop_count
);

    // Memory holds everything except the head, which lives in the output register.
    localparam int unsigned MEM_D = DEPTH - 1;
    localparam int unsigned PTR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    logic [MAX_BITS-1:0]   mem_data [MEM_D];
    logic [LEN_W-1:0]      mem_bits [MEM_D];

    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  out_valid_q, out_valid_d;
    logic [MAX_BITS-1:0]   out_data_q, out_data_d;
    logic [LEN_W-1:0]      out_bits_q, out_bits_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic [NUM_PORTS-1:0]  grant;
    logic                  grant_valid;
    logic [MAX_BITS-1:0]   sel_data;
    logic [LEN_W-1:0]      sel_bits, st_bits;
    logic                  is_zero, push, pop, load, bypass, mem_wr;
    logic [CNT_W-1:0]      mem_cnt;
    logic                  mem_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MEM_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (in_valid),
        .enable      (!full_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Grants are suppressed while reset is held so no producer sees a phantom handshake.
    assign in_ready = grant & {NUM_PORTS{reset_n}};

    // Select the granted producer's payload.
    always_comb begin
        sel_data = '0;
        sel_bits = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*MAX_BITS +: MAX_BITS];
                sel_bits = in_bits[i*LEN_W +: LEN_W];
            end
        end
    end

    assign is_zero   = (sel_bits == '0);
    assign st_bits   = (sel_bits > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : sel_bits;
    assign push      = grant_valid && !is_zero;
    assign pop       = out_valid_q && out_ready;
    assign mem_cnt   = count_q - CNT_W'(out_valid_q);
    assign mem_empty = (mem_cnt == '0);
    assign load      = !out_valid_q || pop;
    assign bypass    = load && mem_empty && push;
    assign mem_wr    = push && !bypass;

    // Next-state for head register, pointers, occupancy and drop counter.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_bits_d  = out_bits_q;
        drop_d      = drop_q;
        if (load) begin
            if (!mem_empty) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_data[rptr_q];
                out_bits_d  = mem_bits[rptr_q];
                rptr_d      = ptr_inc(rptr_q);
            end else if (push) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_bits_d  = st_bits;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (mem_wr) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (grant_valid && is_zero && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Control and head registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bits_q  <= '0;
            drop_q      <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bits_q  <= out_bits_d;
            drop_q      <= drop_d;
        end
    end

    // Message store; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_data[wptr_q] <= sel_data;
            mem_bits[wptr_q] <= st_bits;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_bits   = out_bits_q;
    assign count      = count_q;
    assign full       = full_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_sender_queue.sv
// Self-checking bench for sender_queue against a queue-based reference model.
module tb_sender_queue;

    localparam int unsigned DEPTH = 5;
    localparam int unsigned MB    = 128;
    localparam int unsigned NP    = 3;
    localparam int unsigned LW    = 8;
    localparam int unsigned CW    = 3;

    logic             clk;
    logic             reset_n;
    logic [NP-1:0]    in_valid;
    logic [NP-1:0]    in_ready;
    logic [NP*MB-1:0] in_data;
    logic [NP*LW-1:0] in_bits;
    logic             out_valid;
    logic             out_ready;
    logic [MB-1:0]    out_data;
    logic [LW-1:0]    out_bits;
    logic [CW-1:0]    count;
    logic             full;
    logic [15:0]      drop_count;

    sender_queue #(
        .DEPTH     (DEPTH),
        .MAX_BITS  (MB),
        .NUM_PORTS (NP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_bits    (in_bits),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bits   (out_bits),
        .count      (count),
        .full       (full),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [MB-1:0] data;
        logic [LW-1:0] bits;
    } msg_t;

    msg_t        mq[$];
    int          rr;
    int unsigned drops;
    logic        ov [NP];
    logic [MB-1:0] od [NP];
    logic [LW-1:0] ob [NP];
    logic        ordy;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        if (mq.size() >= int'(DEPTH)) return -1;
        for (int k = 0; k < int'(NP); k++) begin
            int p;
            p = (rr + k) % int'(NP);
            if (ov[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [LW-1:0] rand_bits(input bit allow_odd);
        int unsigned r;
        r = $urandom_range(0, 9);
        if (allow_odd && r == 0) return '0;
        if (allow_odd && r == 1) return LW'($urandom_range(129, 255));
        return LW'($urandom_range(1, 128));
    endfunction

    function automatic logic [MB-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive();
        for (int p = 0; p < int'(NP); p++) begin
            in_valid[p]          = ov[p];
            in_data[p*MB +: MB]  = od[p];
            in_bits[p*LW +: LW]  = ob[p];
        end
        out_ready = ordy;
    endtask

    task automatic offer(input int p, input bit allow_odd);
        if (!ov[p]) begin
            ov[p] = 1'b1;
            od[p] = rand_data();
            ob[p] = rand_bits(allow_odd);
        end
    endtask

    // One clock: drive at negedge, check against model, then advance model to the edge.
    task automatic cycle();
        int g;
        logic [NP-1:0] exp_rdy;
        @(negedge clk);
        drive();
        #1;
        g = exp_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
        chk("count", 128'(count), 128'(mq.size()));
        chk("full", 128'(full), 128'(mq.size() == int'(DEPTH)));
        chk("drop_count", 128'(drop_count), 128'(drops));
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_bits", 128'(out_bits), 128'(mq[0].bits));
        end
        if (mq.size() != 0 && ordy) void'(mq.pop_front());
        if (g >= 0) begin
            if (ob[g] == '0) begin
                if (drops < 32'hFFFF) drops++;
            end else begin
                mq.push_back('{data: od[g], bits: (ob[g] > LW'(MB)) ? LW'(MB) : ob[g]});
            end
            rr = (g + 1) % int'(NP);
            ov[g] = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic clear_offers();
        for (int p = 0; p < int'(NP); p++) ov[p] = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rr      = 0;
        drops   = 0;
        reset_n = 1'b0;
        for (int p = 0; p < int'(NP); p++) begin
            ov[p] = 1'b1;
            od[p] = rand_data();
            ob[p] = 8'd4;
        end
        ordy = 1'b0;
        drive();
        #2;
        // Reset state, with every producer offering.
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_drop", 128'(drop_count), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        clear_offers();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single push into empty queue: head valid one edge later.
        ov[0] = 1'b1; od[0] = 128'hA5; ob[0] = 8'd8;
        cycle();
        #1;
        chk("bypass_valid", 128'(out_valid), 128'(1));
        chk("bypass_data", out_data, 128'hA5);
        chk("bypass_bits", 128'(out_bits), 128'(8));
        chk("bypass_count", 128'(count), 128'(1));
        cycle();

        // Fill with the sender stalled.
        repeat (6) begin
            offer(0, 1'b0);
            cycle();
        end
        #1;
        chk("fill_full", 128'(full), 128'(1));
        chk("fill_count", 128'(count), 128'(DEPTH));

        // Concurrent push and pop around the full boundary.
        ordy = 1'b1;
        repeat (20) begin
            offer(1, 1'b0);
            cycle();
        end
        clear_offers();
        repeat (8) cycle();

        // All producers busy: strict rotation.
        repeat (12) begin
            for (int p = 0; p < int'(NP); p++) offer(p, 1'b0);
            cycle();
        end
        clear_offers();
        repeat (8) cycle();

        // Port 1 idle: rotation skips it.
        repeat (12) begin
            offer(0, 1'b0);
            offer(2, 1'b0);
            cycle();
        end
        clear_offers();
        repeat (8) cycle();

        // Zero-length drops then an over-length message.
        ordy = 1'b0;
        repeat (3) begin
            ov[2] = 1'b1; od[2] = rand_data(); ob[2] = 8'd0;
            cycle();
        end
        ov[2] = 1'b1; od[2] = rand_data(); ob[2] = 8'd200;
        cycle();
        cycle();
        #1;
        chk("drop_three", 128'(drop_count), 128'(3));
        chk("clamp_bits", 128'(out_bits), 128'(MB));
        chk("clamp_count", 128'(count), 128'(1));

        // Randomised traffic with random back-pressure.
        repeat (400) begin
            for (int p = 0; p < int'(NP); p++) begin
                if ($urandom_range(0, 1) == 1) offer(p, 1'b1);
            end
            ordy = ($urandom_range(0, 99) < 60);
            cycle();
        end

        // Reset asserted mid-cycle with three messages held.
        clear_offers();
        ordy = 1'b1;
        repeat (8) cycle();
        ordy = 1'b0;
        repeat (3) begin
            offer(0, 1'b0);
            cycle();
        end
        @(negedge clk);
        for (int p = 0; p < int'(NP); p++) offer(p, 1'b0);
        drive();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        chk("mid_rst_full", 128'(full), 128'(0));
        mq.delete();
        rr    = 0;
        drops = 0;
        clear_offers();
        drive();
        @(negedge clk);
        reset_n = 1'b1;
        ov[1] = 1'b1; od[1] = 128'h1234_5678; ob[1] = 8'd16;
        cycle();
        #1;
        chk("post_rst_valid", 128'(out_valid), 128'(1));
        chk("post_rst_data", out_data, 128'h1234_5678);
        ordy = 1'b1;
        repeat (4) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
